// File: rtl/bw_erosion_core.sv
// ---------------------------------------------------------------------------
// bw_erosion_core
//
// Binary-morphology pixel core with two independent two-stage pipelines that
// share one clock and reset:
//   * threshold path : grayscale pixel -> FG_VAL / BG_VAL (unsigned >=)
//   * erosion path   : 3x3 binarized window -> eroded centre pixel
// A result and its one-cycle valid pulse appear two clocks after the
// enabled sampling edge. Outputs hold their last value between results.
//
// Optional feature (macro BOUNDARY_OUT_EN):
//   defined   : kenar_o = centre minus eroded (FG_VAL when the stage-1
//               centre is FG_VAL and the erosion result is BG_VAL),
//               registered alongside ero_o with the same timing.
//   undefined : kenar_o is tied to BG_VAL.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   bw_en_i      threshold-path strobe; veri_i/esik_i sampled this cycle
//   veri_i       grayscale pixel
//   esik_i       threshold value
//   bw_o         binarized pixel
//   bw_valid_o   one-cycle pulse, bw_o updated
//   ero_en_i     erosion-path strobe; g0_i..g8_i sampled this cycle
//   g0_i..g8_i   3x3 window, row-major (g0 top-left, g4 centre)
//   ero_o        eroded centre pixel
//   ero_valid_o  one-cycle pulse, ero_o updated
//   kenar_o      boundary pixel (see optional feature)
// ---------------------------------------------------------------------------
module bw_erosion_core #(
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] FG_VAL  = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] BG_VAL  = '0,
    parameter logic [8:0]        SE_MASK = 9'h1FF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bw_en_i,
    input  logic [DATA_W-1:0] veri_i,
    input  logic [DATA_W-1:0] esik_i,
    output logic [DATA_W-1:0] bw_o,
    output logic              bw_valid_o,
    input  logic              ero_en_i,
    input  logic [DATA_W-1:0] g0_i,
    input  logic [DATA_W-1:0] g1_i,
    input  logic [DATA_W-1:0] g2_i,
    input  logic [DATA_W-1:0] g3_i,
    input  logic [DATA_W-1:0] g4_i,
    input  logic [DATA_W-1:0] g5_i,
    input  logic [DATA_W-1:0] g6_i,
    input  logic [DATA_W-1:0] g7_i,
    input  logic [DATA_W-1:0] g8_i,
    output logic [DATA_W-1:0] ero_o,
    output logic              ero_valid_o,
    output logic [DATA_W-1:0] kenar_o
);

    localparam int unsigned WIN_W = 9 * DATA_W;

    function automatic logic [DATA_W-1:0] threshold_px(
        input logic [DATA_W-1:0] px,
        input logic [DATA_W-1:0] thr
    );
        return (px >= thr) ? FG_VAL : BG_VAL;
    endfunction

    // Only an exact FG_VAL counts as set; masked-off taps are ignored, so an
    // empty mask always erodes to foreground.
    function automatic logic erode_hit(input logic [WIN_W-1:0] win);
        logic hit;
        hit = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (SE_MASK[k] && (win[k*DATA_W +: DATA_W] != FG_VAL))
                hit = 1'b0;
        end
        return hit;
    endfunction

    logic [WIN_W-1:0]  win_in;
    logic [DATA_W-1:0] px_p1;
    logic [DATA_W-1:0] thr_p1;
    logic              vld_bw_p1;
    logic [WIN_W-1:0]  win_p1;
    logic              vld_ero_p1;

    // g0 occupies the least-significant slot so tap k sits at slice k.
    assign win_in = {g8_i, g7_i, g6_i, g5_i, g4_i, g3_i, g2_i, g1_i, g0_i};

    // ---- stage 1: input capture ------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px_p1      <= '0;
            thr_p1     <= '0;
            vld_bw_p1  <= 1'b0;
            win_p1     <= '0;
            vld_ero_p1 <= 1'b0;
        end else begin
            vld_bw_p1  <= bw_en_i;
            vld_ero_p1 <= ero_en_i;
            if (bw_en_i) begin
                px_p1  <= veri_i;
                thr_p1 <= esik_i;
            end
            if (ero_en_i)
                win_p1 <= win_in;
        end
    end

    // ---- stage 2: result registers ---------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bw_o        <= BG_VAL;
            bw_valid_o  <= 1'b0;
            ero_o       <= BG_VAL;
            ero_valid_o <= 1'b0;
        end else begin
            bw_valid_o  <= vld_bw_p1;
            ero_valid_o <= vld_ero_p1;
            if (vld_bw_p1)
                bw_o <= threshold_px(px_p1, thr_p1);
            if (vld_ero_p1)
                ero_o <= erode_hit(win_p1) ? FG_VAL : BG_VAL;
        end
    end

`ifdef BOUNDARY_OUT_EN
    logic [DATA_W-1:0] kenar_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kenar_q <= BG_VAL;
        end else if (vld_ero_p1) begin
            kenar_q <= ((win_p1[4*DATA_W +: DATA_W] == FG_VAL) && !erode_hit(win_p1))
                       ? FG_VAL : BG_VAL;
        end
    end

    assign kenar_o = kenar_q;
`else
    assign kenar_o = BG_VAL;
`endif

endmodule

// File: tb/tb_bw_erosion_core.sv
module tb_bw_erosion_core;

    logic       clk;
    logic       rst_i;
    logic       bw_en_i;
    logic [7:0] veri_i;
    logic [7:0] esik_i;
    logic       ero_en_i;
    logic [7:0] g0, g1, g2, g3, g4, g5, g6, g7, g8;

    logic [7:0] bw_o, ero_o, kenar_o;
    logic       bw_valid_o, ero_valid_o;
    logic [7:0] bw_x, ero_x, kenar_x;
    logic       bw_valid_x, ero_valid_x;

    int errors = 0;
    int checks = 0;

    logic [7:0] thr_vals [5];
    logic [7:0] thr_exp  [5];

    bw_erosion_core dut (
        .clk_i(clk), .rst_i(rst_i),
        .bw_en_i(bw_en_i), .veri_i(veri_i), .esik_i(esik_i),
        .bw_o(bw_o), .bw_valid_o(bw_valid_o),
        .ero_en_i(ero_en_i),
        .g0_i(g0), .g1_i(g1), .g2_i(g2), .g3_i(g3), .g4_i(g4),
        .g5_i(g5), .g6_i(g6), .g7_i(g7), .g8_i(g8),
        .ero_o(ero_o), .ero_valid_o(ero_valid_o), .kenar_o(kenar_o)
    );

    // Cross-shaped structuring element: taps g1, g3, g4, g5, g7.
    bw_erosion_core #(.SE_MASK(9'h0BA)) dut_x (
        .clk_i(clk), .rst_i(rst_i),
        .bw_en_i(bw_en_i), .veri_i(veri_i), .esik_i(esik_i),
        .bw_o(bw_x), .bw_valid_o(bw_valid_x),
        .ero_en_i(ero_en_i),
        .g0_i(g0), .g1_i(g1), .g2_i(g2), .g3_i(g3), .g4_i(g4),
        .g5_i(g5), .g6_i(g6), .g7_i(g7), .g8_i(g8),
        .ero_o(ero_x), .ero_valid_o(ero_valid_x), .kenar_o(kenar_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_all(input logic [7:0] v);
        g0 = v; g1 = v; g2 = v; g3 = v; g4 = v; g5 = v; g6 = v; g7 = v; g8 = v;
    endtask

    // Strobe erosion for one cycle; returns at the negedge where the result
    // is visible (two clocks after the sampling edge).
    task automatic pulse_ero();
        ero_en_i = 1'b1;
        @(negedge clk);
        ero_en_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bw_en_i = 1'b0; ero_en_i = 1'b0;
        veri_i = 8'd0; esik_i = 8'd140;
        set_all(8'd0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bw_o !== 8'd0) begin errors++; $display("FAIL reset_bw_o got=%0d exp=0", bw_o); end
        checks++; if (ero_o !== 8'd0) begin errors++; $display("FAIL reset_ero_o got=%0d exp=0", ero_o); end
        checks++; if (bw_valid_o !== 1'b0) begin errors++; $display("FAIL reset_bw_valid got=%0b exp=0", bw_valid_o); end
        checks++; if (ero_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ero_valid got=%0b exp=0", ero_valid_o); end
        checks++; if (kenar_o !== 8'd0) begin errors++; $display("FAIL reset_kenar got=%0d exp=0", kenar_o); end
    endtask

    task automatic test_threshold();
        thr_vals[0] = 8'd139; thr_exp[0] = 8'd0;
        thr_vals[1] = 8'd140; thr_exp[1] = 8'd255;
        thr_vals[2] = 8'd141; thr_exp[2] = 8'd255;
        thr_vals[3] = 8'd0;   thr_exp[3] = 8'd0;
        thr_vals[4] = 8'd255; thr_exp[4] = 8'd255;
        esik_i = 8'd140;
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                checks++;
                if (bw_o !== thr_exp[i-2] || bw_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL thr_stream[%0d] got=%0d/v%0b exp=%0d/v1", i-2, bw_o, bw_valid_o, thr_exp[i-2]);
                end
            end
            if (i < 5) begin
                bw_en_i = 1'b1; veri_i = thr_vals[i];
            end else begin
                bw_en_i = 1'b0; veri_i = 8'd0;
            end
            @(negedge clk);
        end
        checks++; if (bw_valid_o !== 1'b0) begin errors++; $display("FAIL thr_valid_drop got=%0b exp=0", bw_valid_o); end
        checks++; if (bw_o !== 8'd255) begin errors++; $display("FAIL thr_hold got=%0d exp=255", bw_o); end
    endtask

    task automatic test_erosion();
        set_all(8'd255);
        pulse_ero();
        checks++; if (ero_o !== 8'd255 || ero_valid_o !== 1'b1) begin errors++; $display("FAIL ero_all_fg got=%0d/v%0b exp=255/v1", ero_o, ero_valid_o); end
        g4 = 8'd0;
        pulse_ero();
        checks++; if (ero_o !== 8'd0) begin errors++; $display("FAIL ero_centre_bg got=%0d exp=0", ero_o); end
        checks++; if (ero_x !== 8'd0) begin errors++; $display("FAIL ero_x_centre_bg got=%0d exp=0", ero_x); end
        g4 = 8'd255; g0 = 8'd254;
        pulse_ero();
        checks++; if (ero_o !== 8'd0) begin errors++; $display("FAIL ero_midgrey got=%0d exp=0", ero_o); end
        checks++; if (ero_x !== 8'd255) begin errors++; $display("FAIL ero_x_corner_ignored got=%0d exp=255", ero_x); end
        @(negedge clk);
        checks++; if (ero_valid_o !== 1'b0) begin errors++; $display("FAIL ero_valid_single got=%0b exp=0", ero_valid_o); end
    endtask

    task automatic test_mask();
        set_all(8'd255);
        g0 = 8'd0; g2 = 8'd0; g6 = 8'd0; g8 = 8'd0;
        pulse_ero();
        checks++; if (ero_x !== 8'd255 || ero_valid_x !== 1'b1) begin errors++; $display("FAIL mask_cross_fg got=%0d/v%0b exp=255/v1", ero_x, ero_valid_x); end
        checks++; if (ero_o !== 8'd0) begin errors++; $display("FAIL mask_full_corners got=%0d exp=0", ero_o); end
        g1 = 8'd0;
        pulse_ero();
        checks++; if (ero_x !== 8'd0) begin errors++; $display("FAIL mask_cross_g1 got=%0d exp=0", ero_x); end
    endtask

    task automatic test_back_to_back();
        veri_i = 8'd200; esik_i = 8'd100;
        set_all(8'd255);
        bw_en_i = 1'b1; ero_en_i = 1'b1;
        @(negedge clk);
        bw_en_i = 1'b0; ero_en_i = 1'b0;
        veri_i = 8'd0; esik_i = 8'd255; set_all(8'd0);
        @(negedge clk);
        checks++; if (bw_o !== 8'd255 || bw_valid_o !== 1'b1) begin errors++; $display("FAIL par_bw got=%0d/v%0b exp=255/v1", bw_o, bw_valid_o); end
        checks++; if (ero_o !== 8'd255 || ero_valid_o !== 1'b1) begin errors++; $display("FAIL par_ero got=%0d/v%0b exp=255/v1", ero_o, ero_valid_o); end
        repeat (2) @(negedge clk);
        checks++; if (bw_o !== 8'd255 || bw_valid_o !== 1'b0) begin errors++; $display("FAIL hold_bw got=%0d/v%0b exp=255/v0", bw_o, bw_valid_o); end
        checks++; if (ero_o !== 8'd255 || ero_valid_o !== 1'b0) begin errors++; $display("FAIL hold_ero got=%0d/v%0b exp=255/v0", ero_o, ero_valid_o); end
    endtask

    task automatic test_boundary();
        set_all(8'd255); g0 = 8'd0;
        pulse_ero();
        checks++; if (ero_o !== 8'd0) begin errors++; $display("FAIL bnd_ero got=%0d exp=0", ero_o); end
`ifdef BOUNDARY_OUT_EN
        checks++; if (kenar_o !== 8'd255) begin errors++; $display("FAIL bnd_edge got=%0d exp=255", kenar_o); end
        set_all(8'd255);
        pulse_ero();
        checks++; if (kenar_o !== 8'd0) begin errors++; $display("FAIL bnd_interior got=%0d exp=0", kenar_o); end
        g4 = 8'd0;
        pulse_ero();
        checks++; if (kenar_o !== 8'd0) begin errors++; $display("FAIL bnd_bg_centre got=%0d exp=0", kenar_o); end
`else
        checks++; if (kenar_o !== 8'd0) begin errors++; $display("FAIL bnd_tied got=%0d exp=0", kenar_o); end
`endif
    endtask

    task automatic test_reset_midflight();
        veri_i = 8'd200; esik_i = 8'd100;
        set_all(8'd255);
        bw_en_i = 1'b1; ero_en_i = 1'b1;
        @(negedge clk);
        bw_en_i = 1'b0; ero_en_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (bw_valid_o !== 1'b0 || ero_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid0 got=%0b/%0b exp=0/0", bw_valid_o, ero_valid_o); end
        @(negedge clk);
        checks++; if (bw_valid_o !== 1'b0 || ero_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid1 got=%0b/%0b exp=0/0", bw_valid_o, ero_valid_o); end
        checks++; if (bw_o !== 8'd0 || ero_o !== 8'd0) begin errors++; $display("FAIL mid_rst_out got=%0d/%0d exp=0/0", bw_o, ero_o); end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_erosion();
        test_mask();
        test_back_to_back();
        test_boundary();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bw_erosion_core.md
Name: bw_erosion_core

Overview:
- Pixel-processing core for the binary morphology path: grayscale-to-binary thresholding plus 3x3 binary erosion.
- Two independent registered pipelines share one clock and reset. The frame-level controller feeds single pixels to the threshold path and 3x3 windows of binarized pixels to the erosion path.
- Results feed frame buffers; the boundary image is derived downstream as binary minus eroded.

Parameters:
- DATA_W, 8, pixel width in bits.
- FG_VAL, {DATA_W{1'b1}} (255), foreground/white value emitted and recognised.
- BG_VAL, 0, background/black value emitted.
- SE_MASK, 9'h1FF, structuring-element mask; bit k enables window tap gk_i; a cleared bit ignores that tap.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- bw_en_i  in  1  threshold-path input strobe; sample veri_i/esik_i this cycle.
- veri_i  in  DATA_W  grayscale pixel.
- esik_i  in  DATA_W  threshold value (system default 140).
- bw_o  out  DATA_W  binarized pixel.
- bw_valid_o  out  1  one-cycle pulse, bw_o updated this cycle.
- ero_en_i  in  1  erosion-path input strobe; sample g0_i..g8_i this cycle.
- g0_i..g8_i  in  DATA_W each  3x3 window, row-major (g0 top-left, g4 centre, g8 bottom-right).
- ero_o  out  DATA_W  eroded centre pixel.
- ero_valid_o  out  1  one-cycle pulse, ero_o updated this cycle.
- kenar_o  out  DATA_W  boundary pixel (only with the optional feature).

Behaviour:
- Reset (rst_i=1 at clock edge): bw_o, ero_o, kenar_o = BG_VAL; bw_valid_o, ero_valid_o = 0; all pipeline stage registers and stage-valid bits cleared. Reset has priority over enables.
- Threshold path, 2-stage:
  - Stage 1 registers veri_i, esik_i and a valid bit when bw_en_i=1.
  - Stage 2: bw_o = FG_VAL if pixel >= threshold, else BG_VAL. Comparison is unsigned.
- Erosion path, 2-stage:
  - Stage 1 registers all nine taps and a valid bit when ero_en_i=1.
  - Stage 2: ero_o = FG_VAL iff every tap k with SE_MASK[k]=1 equals FG_VAL exactly; otherwise BG_VAL.
  - Any value other than FG_VAL, including mid-grey, counts as not set.
  - SE_MASK=0 yields FG_VAL.
- Latency: result and valid pulse appear 2 clocks after the enabled sampling edge, on both paths.
- Throughput: 1 sample/clock per path. Enables held high for many cycles produce a result every cycle; identical inputs give identical outputs.
- When no new result arrives, outputs hold their last value and the valid output is 0. Enable low does not clear outputs.
- The two paths are fully independent; simultaneous enables are processed in parallel with no interaction.
- Reset asserted mid-flight discards in-flight samples: no valid pulse for them after reset deasserts.
- Inputs need to be stable only at the sampling edge.

Optional Feature:
- Macro BOUNDARY_OUT_EN.
- Defined: kenar_o is registered alongside ero_o with identical latency and valid timing.
  - kenar_o = FG_VAL when stage-1 g4 == FG_VAL and the erosion result is BG_VAL; else BG_VAL.
  - This is centre minus eroded, clamped at 0.
- Undefined: kenar_o port is still present, tied to BG_VAL, and no extra logic is built.

Test Plan:
- Reset then idle: bw_o=0, ero_o=0, both valids 0. Apply rst_i mid-flight with a sample staged: no valid pulse follows.
- esik_i=140; veri_i = 139, 140, 141, 0, 255 on consecutive enabled cycles -> bw_o = 0, 255, 255, 0, 255, each 2 clocks later with bw_valid_o=1 each cycle.
- All taps 255, ero_en_i=1 -> ero_o=255 after 2 clocks. Then g4=0, rest 255 -> 0. Then g0=254, rest 255 -> 0.
- SE_MASK=9'h0BA (cross), g0=g2=g6=g8=0, cross taps 255 -> ero_o=255. Then g1=0 -> ero_o=0.
- Simultaneous bw_en_i and ero_en_i with unrelated data -> both correct results in the same cycle. Then drop enables -> outputs hold, valids 0.
- With BOUNDARY_OUT_EN: g4=255, g0=0, rest 255 -> ero_o=0, kenar_o=255. All 255 -> kenar_o=0. g4=0 -> kenar_o=0.
